user_input_m: RTL and testbench
===============================

// Module: user_input_m
// PURPOSE
// - Front-panel input stage, directly upstream of counter_m and alarm_m.
// - Turns raw button levels into the set_flag/set_time and alarm_flag/alarm_time signals those modules consume.
// - Runs an edit FSM for setting the time (hour/min/sec) and the alarm (hour/min), plus an alarm arm toggle.
// - Timestamps are seconds since midnight, 0..86399.
// PARAMETERS
// - TIMEOUT  default 30  clock edges with no accepted button in an edit state before auto-exit to IDLE
// PORTS
// - clock          in   1   system clock; all state changes on posedge
// - reset          in   1   synchronous, active-high reset
// - btn_time       in   1   button level: enter/advance time edit
// - btn_alarm      in   1   button level: enter/advance alarm edit
// - btn_arm        in   1   button level: toggle alarm armed (IDLE only)
// - btn_up         in   1   button level: increment current field
// - btn_down       in   1   button level: decrement current field
// - counter_state  in   17  current timestamp from counter_m
// - set_flag       out  1   hold counter_m at set_time
// - set_time       out  17  edited time, seconds
// - alarm_flag     out  1   alarm enabled, to alarm_m
// - alarm_time     out  17  committed alarm setpoint, seconds
// - mode           out  3   0 IDLE, 1 T_HOUR, 2 T_MIN, 3 T_SEC, 4 A_HOUR, 5 A_MIN
// BEHAVIOUR
// - Reset: all outputs 0. mode=IDLE, fields 0, armed=0, timeout counter 0.
// - Button sampling and events:
//   - Each button is registered once.
//   - An event is the sampled level high while the previous sample is low (rising edge).
//   - Holding a button produces exactly one event.
//   - State and outputs update on the edge that detects the event (1 cycle after the sampled rise).
// - Priority within one cycle: btn_time > btn_alarm > btn_arm > up/down.
//   - up and down together: no change.
// - FSM transitions:
//   - IDLE   --time-->  T_HOUR. Load h/m/s fields from counter_state (h=cs/3600, m=(cs/60)%60, s=cs%60).
//   - T_HOUR --time-->  T_MIN --time--> T_SEC --time--> IDLE.
//   - IDLE   --alarm--> A_HOUR. Load alarm h/m from alarm_time.
//   - A_HOUR --alarm--> A_MIN --alarm--> IDLE. On this exit, alarm_time <= ah*3600 + am*60 (alarm sec always 0).
//   - btn_alarm in T_* states and btn_time in A_* states are ignored.
//   - btn_arm toggles armed in IDLE only; ignored elsewhere.
// - Field arithmetic:
//   - up/down adjust only the field selected by mode.
//   - Wrap within the field: hour 0..23, min/sec 0..59. 23+1 -> 0, 0-1 -> 23, 59+1 -> 0, 0-1 -> 59.
//   - No carry into neighbouring fields.
// - set_time = h*3600 + m*60 + s, registered.
//   - Updates on every field change and on entry to T_HOUR.
//   - Holds its last value in IDLE.
// - set_flag = 1 exactly while mode is T_*.
//   - It is 1 on the same edge that enters T_HOUR and 0 on the edge that returns to IDLE.
//   - counter_state is ignored while set_flag = 1.
// - alarm_flag = armed && mode not in A_*.
//   - Forced 0 during alarm edit so alarm_m clears any ringing state.
//   - Restored to armed on exit.
// - Timeout:
//   - The counter clears on every accepted event and on every state entry, and increments each edge in T_*/A_*.
//   - On reaching TIMEOUT: return to IDLE exactly as if the final field were confirmed (A_*: alarm_time commits).
//   - Counter held at 0 in IDLE.
// - Reset mid-edit: next edge gives mode=IDLE, set_flag=0, no alarm commit, edited fields discarded.
// - set_time and alarm_time never exceed 86399 by construction.
// TESTING
// - Entry: reset; counter_state=34953; pulse btn_time -> next edge mode=1, set_flag=1, set_time=34953 (09:42:33).
// - Hour wrap: in T_HOUR at h=9, 15 separate btn_up pulses -> h=0, set_time=2553. Holding btn_up 10 cycles gives only +1.
// - Min/sec wrap: btn_time to T_MIN (m=42); btn_down x43 -> m=59. btn_time, btn_up at s=59 -> s=0. btn_time -> mode=0, set_flag=0.
// - Alarm: armed via btn_arm (alarm_flag=1). btn_alarm -> alarm_flag=0. up x2 (h=2), btn_alarm, down x1 (m=59), btn_alarm -> alarm_time=10740, alarm_flag=1.
// - Timeout: enter T_HOUR, no buttons for 30 edges -> mode=0, set_flag=0. Same in A_MIN -> alarm_time committed.
// - Conflicts: up+down same cycle -> no change. btn_time+btn_up same cycle -> advance only. reset in T_MIN -> all outputs 0 next edge.

Source files
------------

// File: rtl/user_input_m_if.sv
// Front-panel signal bundle between the panel/counter side and the user_input_m input stage.
interface user_input_m_if;
    logic        btn_time;
    logic        btn_alarm;
    logic        btn_arm;
    logic        btn_up;
    logic        btn_down;
    logic [16:0] counter_state;
    logic        set_flag;
    logic [16:0] set_time;
    logic        alarm_flag;
    logic [16:0] alarm_time;
    logic [2:0]  mode;

    // Panel side: drives button levels and the live timestamp, observes edit results.
    modport master (
        output btn_time, btn_alarm, btn_arm, btn_up, btn_down, counter_state,
        input  set_flag, set_time, alarm_flag, alarm_time, mode
    );

    // Input stage side.
    modport slave (
        input  btn_time, btn_alarm, btn_arm, btn_up, btn_down, counter_state,
        output set_flag, set_time, alarm_flag, alarm_time, mode
    );
endinterface

// File: rtl/user_input_m.sv
// Front-panel input stage: button edge detection, time/alarm edit FSM,
// alarm arm toggle and inactivity timeout. Timestamps are seconds since midnight.
module user_input_m #(
    parameter int TIMEOUT = 30
) (
    input logic           clock,
    input logic           reset,
    user_input_m_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_T_HOUR = 3'd1;
    localparam logic [2:0] S_T_MIN  = 3'd2;
    localparam logic [2:0] S_T_SEC  = 3'd3;
    localparam logic [2:0] S_A_HOUR = 3'd4;
    localparam logic [2:0] S_A_MIN  = 3'd5;

    localparam int B_TIME  = 0;
    localparam int B_ALARM = 1;
    localparam int B_ARM   = 2;
    localparam int B_UP    = 3;
    localparam int B_DOWN  = 4;

    logic [4:0]  btn_raw;
    logic [4:0]  btn_reg, btn_prev_reg;
    logic [4:0]  btn_event;

    logic [2:0]  mode_reg, mode_next;
    logic [4:0]  hour_reg, hour_next;
    logic [5:0]  min_reg, min_next;
    logic [5:0]  sec_reg, sec_next;
    logic [4:0]  a_hour_reg, a_hour_next;
    logic [5:0]  a_min_reg, a_min_next;
    logic        armed_reg, armed_next;
    logic [15:0] timer_reg, timer_next;
    logic [16:0] set_time_reg, set_time_next;
    logic [16:0] alarm_time_reg, alarm_time_next;

    logic        accepted;
    logic        commit;
    logic        step_valid;
    logic        step_up;
    logic        next_is_time_edit;

    logic [4:0]  cs_hour;
    logic [5:0]  cs_min, cs_sec;
    logic [4:0]  al_hour;
    logic [5:0]  al_min;

    // Wrapping +/-1 on a field whose legal range is 0..top.
    function automatic logic [5:0] wrap_step(input logic [5:0] value, input logic [5:0] top,
                                             input logic up);
        logic [5:0] r;
        if (up) r = (value == top) ? 6'd0 : value + 6'd1;
        else    r = (value == 6'd0) ? top : value - 6'd1;
        return r;
    endfunction

    assign btn_raw = {bus.btn_down, bus.btn_up, bus.btn_arm, bus.btn_alarm, bus.btn_time};

    // Rising edge of each registered button level is one event; holding produces no more.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_edge
            assign btn_event[gi] = btn_reg[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    // up and down together cancel out.
    assign step_valid = btn_event[B_UP] ^ btn_event[B_DOWN];
    assign step_up    = btn_event[B_UP];

    // Field decomposition of the live counter and of the committed alarm setpoint.
    assign cs_hour = 5'(bus.counter_state / 17'd3600);
    assign cs_min  = 6'((bus.counter_state / 17'd60) % 17'd60);
    assign cs_sec  = 6'(bus.counter_state % 17'd60);
    assign al_hour = 5'(alarm_time_reg / 17'd3600);
    assign al_min  = 6'((alarm_time_reg / 17'd60) % 17'd60);

    // Register raw button levels and keep the previous sample for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            btn_reg      <= 5'd0;
            btn_prev_reg <= 5'd0;
        end else begin
            btn_reg      <= btn_raw;
            btn_prev_reg <= btn_reg;
        end
    end

    // Edit FSM, field arithmetic, inactivity timeout and alarm commit.
    always_comb begin
        mode_next       = mode_reg;
        hour_next       = hour_reg;
        min_next        = min_reg;
        sec_next        = sec_reg;
        a_hour_next     = a_hour_reg;
        a_min_next      = a_min_reg;
        armed_next      = armed_reg;
        alarm_time_next = alarm_time_reg;
        timer_next      = 16'd0;
        accepted        = 1'b0;
        commit          = 1'b0;

        case (mode_reg)
            S_IDLE: begin
                if (btn_event[B_TIME]) begin
                    mode_next = S_T_HOUR;
                    hour_next = cs_hour;
                    min_next  = cs_min;
                    sec_next  = cs_sec;
                end else if (btn_event[B_ALARM]) begin
                    mode_next   = S_A_HOUR;
                    a_hour_next = al_hour;
                    a_min_next  = al_min;
                end else if (btn_event[B_ARM]) begin
                    armed_next = ~armed_reg;
                end
            end
            S_T_HOUR, S_T_MIN, S_T_SEC: begin
                if (btn_event[B_TIME]) begin
                    accepted  = 1'b1;
                    mode_next = (mode_reg == S_T_SEC) ? S_IDLE : mode_reg + 3'd1;
                end else if (step_valid) begin
                    accepted = 1'b1;
                    case (mode_reg)
                        S_T_HOUR: hour_next = 5'(wrap_step({1'b0, hour_reg}, 6'd23, step_up));
                        S_T_MIN:  min_next  = wrap_step(min_reg, 6'd59, step_up);
                        default:  sec_next  = wrap_step(sec_reg, 6'd59, step_up);
                    endcase
                end
            end
            S_A_HOUR, S_A_MIN: begin
                if (btn_event[B_ALARM]) begin
                    accepted = 1'b1;
                    if (mode_reg == S_A_MIN) begin
                        mode_next = S_IDLE;
                        commit    = 1'b1;
                    end else begin
                        mode_next = S_A_MIN;
                    end
                end else if (step_valid) begin
                    accepted = 1'b1;
                    if (mode_reg == S_A_HOUR)
                        a_hour_next = 5'(wrap_step({1'b0, a_hour_reg}, 6'd23, step_up));
                    else
                        a_min_next  = wrap_step(a_min_reg, 6'd59, step_up);
                end
            end
            default: mode_next = S_IDLE;
        endcase

        // A quiet edit state counts edges; the TIMEOUT-th quiet edge confirms and leaves.
        if (mode_reg != S_IDLE && !accepted) begin
            if (timer_reg == 16'(TIMEOUT - 1)) begin
                mode_next = S_IDLE;
                commit    = (mode_reg == S_A_HOUR) || (mode_reg == S_A_MIN);
            end else begin
                timer_next = timer_reg + 16'd1;
            end
        end

        if (commit)
            alarm_time_next = 17'(a_hour_next) * 17'd3600 + 17'(a_min_next) * 17'd60;
    end

    // set_time tracks the edited fields while in a time-edit state and holds otherwise.
    always_comb begin
        next_is_time_edit = (mode_next == S_T_HOUR) || (mode_next == S_T_MIN) ||
                            (mode_next == S_T_SEC);
        set_time_next     = set_time_reg;
        if (next_is_time_edit)
            set_time_next = 17'(hour_next) * 17'd3600 + 17'(min_next) * 17'd60 + 17'(sec_next);
    end

    // State registers; reset discards any edit in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_reg       <= S_IDLE;
            hour_reg       <= 5'd0;
            min_reg        <= 6'd0;
            sec_reg        <= 6'd0;
            a_hour_reg     <= 5'd0;
            a_min_reg      <= 6'd0;
            armed_reg      <= 1'b0;
            timer_reg      <= 16'd0;
            set_time_reg   <= 17'd0;
            alarm_time_reg <= 17'd0;
        end else begin
            mode_reg       <= mode_next;
            hour_reg       <= hour_next;
            min_reg        <= min_next;
            sec_reg        <= sec_next;
            a_hour_reg     <= a_hour_next;
            a_min_reg      <= a_min_next;
            armed_reg      <= armed_next;
            timer_reg      <= timer_next;
            set_time_reg   <= set_time_next;
            alarm_time_reg <= alarm_time_next;
        end
    end

    assign bus.mode       = mode_reg;
    assign bus.set_time   = set_time_reg;
    assign bus.alarm_time = alarm_time_reg;
    assign bus.set_flag   = (mode_reg == S_T_HOUR) || (mode_reg == S_T_MIN) || (mode_reg == S_T_SEC);
    // Alarm output is muted during alarm edit so downstream ringing clears.
    assign bus.alarm_flag = armed_reg && !((mode_reg == S_A_HOUR) || (mode_reg == S_A_MIN));
endmodule

// File: tb/tb_user_input_m.sv
// Scoreboard bench for user_input_m: a seconds-based reference model predicts the
// outputs after every clock edge; a monitor compares them against the DUT.
module tb_user_input_m;
    localparam int TIMEOUT = 30;
    localparam bit [4:0] BT = 5'b00001;
    localparam bit [4:0] BA = 5'b00010;
    localparam bit [4:0] BR = 5'b00100;
    localparam bit [4:0] BU = 5'b01000;
    localparam bit [4:0] BD = 5'b10000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    user_input_m_if bus();

    user_input_m #(.TIMEOUT(TIMEOUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  mode;
        logic        set_flag;
        logic [16:0] set_time;
        logic        alarm_flag;
        logic [16:0] alarm_time;
    } out_t;

    out_t exp_q[$];
    out_t mon_exp, mon_act;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cur_cs  = 0;

    // Reference model: modes 0..5, edited values kept as whole seconds.
    int       m_mode, m_edit, m_aedit, m_set_time, m_alarm_time, m_quiet;
    bit       m_armed;
    bit [4:0] m_lvl_now, m_lvl_old;

    function automatic int adjust(input int t, input int field, input int delta);
        int h, mi, s;
        h  = t / 3600;
        mi = (t / 60) % 60;
        s  = t % 60;
        case (field)
            0:       h  = (h + delta + 24) % 24;
            1:       mi = (mi + delta + 60) % 60;
            default: s  = (s + delta + 60) % 60;
        endcase
        return h * 3600 + mi * 60 + s;
    endfunction

    function automatic void model_edge(input bit rst, input bit [4:0] lvl, input int cs);
        bit [4:0] ev;
        bit       acted;
        int       delta, was;
        if (rst) begin
            m_mode = 0; m_edit = 0; m_aedit = 0; m_set_time = 0; m_alarm_time = 0;
            m_quiet = 0; m_armed = 0; m_lvl_now = 0; m_lvl_old = 0;
            return;
        end
        ev        = m_lvl_now & ~m_lvl_old;
        m_lvl_old = m_lvl_now;
        m_lvl_now = lvl;
        acted     = 0;
        was       = m_mode;
        delta     = (ev[3] && !ev[4]) ? 1 : ((ev[4] && !ev[3]) ? -1 : 0);
        if (m_mode == 0) begin
            if (ev[0]) begin
                m_mode = 1; m_edit = cs;
            end else if (ev[1]) begin
                m_mode = 4; m_aedit = m_alarm_time;
            end else if (ev[2]) begin
                m_armed = !m_armed;
            end
        end else if (m_mode <= 3) begin
            if (ev[0]) begin
                acted = 1; m_mode = (m_mode == 3) ? 0 : m_mode + 1;
            end else if (delta != 0) begin
                acted = 1; m_edit = adjust(m_edit, m_mode - 1, delta);
            end
        end else begin
            if (ev[1]) begin
                acted = 1;
                if (m_mode == 5) begin
                    m_alarm_time = m_aedit; m_mode = 0;
                end else begin
                    m_mode = 5;
                end
            end else if (delta != 0) begin
                acted = 1; m_aedit = adjust(m_aedit, m_mode - 4, delta);
            end
        end
        if (was != 0 && !acted) begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
                if (was >= 4) m_alarm_time = m_aedit;
                m_mode = 0;
            end
        end
        if (acted || m_mode == 0 || m_mode != was) m_quiet = 0;
        if (m_mode >= 1 && m_mode <= 3) m_set_time = m_edit;
    endfunction

    // One clock cycle of stimulus; the model's prediction for the next edge is queued.
    task automatic cyc(input bit rst, input bit [4:0] lvl, input int cs);
        out_t e;
        @(negedge clock);
        reset = rst;
        {bus.btn_down, bus.btn_up, bus.btn_arm, bus.btn_alarm, bus.btn_time} = lvl;
        bus.counter_state = 17'(cs);
        model_edge(rst, lvl, cs);
        e.mode       = 3'(m_mode);
        e.set_flag   = (m_mode >= 1 && m_mode <= 3);
        e.set_time   = 17'(m_set_time);
        e.alarm_flag = m_armed && (m_mode < 4);
        e.alarm_time = 17'(m_alarm_time);
        exp_q.push_back(e);
    endtask

    task automatic press(input bit [4:0] b);
        cyc(1'b0, b, cur_cs);
        cyc(1'b0, 5'd0, cur_cs);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 5'd0, cur_cs);
    endtask

    // Monitor: after each edge compare the DUT outputs with the oldest prediction.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {bus.mode, bus.set_flag, bus.set_time, bus.alarm_flag, bus.alarm_time};
                n_total++;
                if (mon_act === mon_exp) begin
                    n_pass++;
                    $display("chk %0d mode=%0d set_flag=%0d set_time=%0d alarm_flag=%0d alarm_time=%0d ok",
                             n_total, mon_act.mode, mon_act.set_flag, mon_act.set_time,
                             mon_act.alarm_flag, mon_act.alarm_time);
                end else begin
                    $display("FAIL outputs chk %0d: got mode=%0d set_flag=%0d set_time=%0d alarm_flag=%0d alarm_time=%0d, want mode=%0d set_flag=%0d set_time=%0d alarm_flag=%0d alarm_time=%0d",
                             n_total, mon_act.mode, mon_act.set_flag, mon_act.set_time,
                             mon_act.alarm_flag, mon_act.alarm_time, mon_exp.mode,
                             mon_exp.set_flag, mon_exp.set_time, mon_exp.alarm_flag,
                             mon_exp.alarm_time);
                end
            end
        end
    end

    initial begin
        bit [4:0] lvl;
        int       waited;
        {bus.btn_down, bus.btn_up, bus.btn_arm, bus.btn_alarm, bus.btn_time} = 5'd0;
        bus.counter_state = 17'd0;

        // Reset and entry from 09:42:33
        cur_cs = 34953;
        repeat (3) cyc(1'b1, 5'd0, cur_cs);
        idle(2);
        press(BT);
        idle(1);

        // Hour wrap by separate presses, then a long hold counts once
        repeat (15) press(BU);
        repeat (10) cyc(1'b0, BU, cur_cs);
        idle(2);

        // Minute wrap downward, second wrap both ways, exit
        press(BT);
        repeat (43) press(BD);
        press(BT);
        repeat (34) press(BD);
        press(BU);
        press(BT);
        idle(2);

        // Arm, alarm edit to 02:59, commit
        press(BR);
        press(BA);
        repeat (2) press(BU);
        press(BA);
        press(BD);
        press(BA);
        idle(2);

        // Timeouts from T_HOUR and from A_MIN
        press(BT);
        idle(TIMEOUT + 5);
        press(BA);
        press(BA);
        press(BU);
        idle(TIMEOUT + 5);

        // Conflicts and reset mid-edit
        cur_cs = 4000;
        press(BT);
        press(BU | BD);
        press(BT | BU);
        press(BU);
        cyc(1'b1, 5'd0, cur_cs);
        idle(3);

        // Randomized button activity
        lvl = 5'd0;
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 5) == 0) lvl[b] = ~lvl[b];
            if ($urandom_range(0, 49) == 0) cur_cs = int'($urandom_range(0, 86399));
            if ($urandom_range(0, 199) == 0) begin
                lvl = 5'd0;
                idle(TIMEOUT + 2);
            end
            cyc(($urandom_range(0, 599) == 0), lvl, cur_cs);
        end
        idle(2);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clock);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
